// File: rtl/daq_ram_pkg.sv
// Shared types and header layout constants for the DAQ frame RAM writer.
package daq_ram_pkg;

  // Frame writer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    HDR   = 2'd3
  } state_t;

  // Header word layout: {seq, len}
  localparam int unsigned HDR_SEQ_LSB = 16;
  localparam int unsigned HDR_LEN_LSB = 0;
  localparam int unsigned HDR_LEN_W   = 16;

  localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage : daq_ram_pkg

// File: rtl/daq_frame_ram_writer.sv
// Frame writer: takes framed samples from an Avalon-ST sink and writes them into
// two ping-pong half-buffers of the on-chip RAM over an Avalon-MM master. Each
// completed frame gets a {seq, len} header at the half-buffer base; the host is
// flagged via buf_full/irq and frees a half with a buf_release pulse.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   st_data/valid/sop/eop, st_ready   Avalon-ST sample sink
//   avm_address/write/writedata/byteenable, avm_waitrequest   Avalon-MM write master
//   enable                        gate for starting new frames
//   buf_release, buf_full, irq    host buffer handshake
//   trunc_err, clr_err            sticky oversize-frame flag and its clear
//   frame_seq                     sequence number of the next header
module daq_frame_ram_writer
  import daq_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEQ_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_valid,
  input  logic              st_sop,
  input  logic              st_eop,
  output logic              st_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic              enable,
  input  logic [1:0]        buf_release,
  output logic [1:0]        buf_full,
  output logic              irq,
  output logic              trunc_err,
  input  logic              clr_err,
  output logic [SEQ_W-1:0]  frame_seq
);

  localparam int unsigned CNT_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};  // BUF_WORDS-1 payload words

  state_t              state_q, state_d;
  logic                cur_q, cur_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [1:0]          full_q, full_d, set_mask;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                hdr_sent_q, hdr_sent_d;
  logic                drop_seen_q, drop_seen_d;
  logic                trunc_q, trunc_d;
  logic                irq_q;
  logic [3:0]          be_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;

  logic                reg_free;
  logic                ready_c;
  logic                ld_en;
  logic [ADDR_W-1:0]   ld_addr;
  logic [DATA_W-1:0]   ld_data;
  logic [DATA_W-1:0]   hdr_word;

  // Holding register can take a new entry when empty or completing this cycle
  assign reg_free = !wr_q || !avm_waitrequest;

  // Header word for the frame in progress
  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_SEQ_LSB +: SEQ_W]     = seq_q;
    hdr_word[HDR_LEN_LSB +: HDR_LEN_W] = HDR_LEN_W'(count_q);
  end

  // Next-state, write-register load and bookkeeping
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    seq_d       = seq_q;
    count_d     = count_q;
    hdr_sent_d  = hdr_sent_q;
    drop_seen_d = drop_seen_q;
    trunc_d     = trunc_q & ~clr_err;
    set_mask    = 2'b00;
    ready_c     = 1'b0;
    ld_en       = 1'b0;
    ld_addr     = addr_q;
    ld_data     = data_q;

    unique case (state_q)
      IDLE: begin
        ready_c = enable && !full_q[cur_q] && reg_free;
        // Non-sop beats are accepted and silently dropped here
        if (st_valid && ready_c && st_sop) begin
          ld_en   = 1'b1;
          ld_addr = {cur_q, CNT_W'(1)};
          ld_data = st_data;
          count_d = CNT_W'(1);
          state_d = st_eop ? HDR : FILL;
        end
      end
      FILL: begin
        ready_c = reg_free;
        if (st_valid && ready_c) begin
          ld_en   = 1'b1;
          ld_addr = {cur_q, count_q + CNT_W'(1)};
          ld_data = st_data;
          count_d = count_q + CNT_W'(1);
          if (st_eop) begin
            state_d = HDR;
          end else if (count_q + CNT_W'(1) == CNT_MAX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        ready_c = 1'b1;
        if (st_valid) begin
          if (!drop_seen_q) begin
            trunc_d = 1'b1;
          end
          drop_seen_d = 1'b1;
          if (st_eop) begin
            drop_seen_d = 1'b0;
            state_d     = HDR;
          end
        end
      end
      HDR: begin
        if (!hdr_sent_q) begin
          if (reg_free) begin
            ld_en      = 1'b1;
            ld_addr    = {cur_q, CNT_W'(0)};
            ld_data    = hdr_word;
            hdr_sent_d = 1'b1;
          end
        end else if (wr_q && !avm_waitrequest) begin
          // Header landed: publish the half and switch to the other one
          set_mask[cur_q] = 1'b1;
          seq_d           = seq_q + SEQ_W'(1);
          cur_d           = !cur_q;
          count_d         = '0;
          hdr_sent_d      = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A set on the same bit as a release wins
    full_d = (full_q & ~buf_release) | set_mask;
  end

  // Registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_q       <= 1'b0;
      seq_q       <= '0;
      full_q      <= 2'b00;
      count_q     <= '0;
      hdr_sent_q  <= 1'b0;
      drop_seen_q <= 1'b0;
      trunc_q     <= 1'b0;
      irq_q       <= 1'b0;
      be_q        <= 4'h0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      seq_q       <= seq_d;
      full_q      <= full_d;
      count_q     <= count_d;
      hdr_sent_q  <= hdr_sent_d;
      drop_seen_q <= drop_seen_d;
      trunc_q     <= trunc_d;
      irq_q       <= |full_d;
      be_q        <= BYTEEN_ALL;
      if (ld_en) begin
        wr_q   <= 1'b1;
        addr_q <= ld_addr;
        data_q <= ld_data;
      end else if (wr_q && !avm_waitrequest) begin
        wr_q <= 1'b0;
      end
    end
  end

  // st_ready is inherently same-cycle (depends on waitrequest); forced low in reset
  assign st_ready       = ready_c & reset_n;
  assign avm_write      = wr_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = data_q;
  assign avm_byteenable = be_q;
  assign buf_full       = full_q;
  assign irq            = irq_q;
  assign trunc_err      = trunc_q;
  assign frame_seq      = seq_q;

endmodule : daq_frame_ram_writer

// File: tb/tb_daq_frame_ram_writer.sv
// Bench for daq_frame_ram_writer: directed frame table, hand-written corner
// sequences and randomized frames checked against a frame-level write model.
module tb_daq_frame_ram_writer;

  logic        clk;
  logic        reset_n;
  logic [31:0] st_data;
  logic        st_valid, st_sop, st_eop, st_ready;
  logic [13:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        enable;
  logic [1:0]  buf_release, buf_full;
  logic        irq, trunc_err, clr_err;
  logic [15:0] frame_seq;

  daq_frame_ram_writer dut (
    .clk(clk), .reset_n(reset_n),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(st_ready),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .enable(enable), .buf_release(buf_release), .buf_full(buf_full), .irq(irq),
    .trunc_err(trunc_err), .clr_err(clr_err), .frame_seq(frame_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] fq[$];
  logic [13:0] last_a;
  logic [31:0] last_d;
  bit          mon_en = 1'b1;
  bit          rnd_stall = 1'b0;
  bit          auto_rel = 1'b0;
  int          m_cur = 0;
  int          m_seq = 0;

  typedef struct {
    logic [1:0]  rel;
    int          n;
    logic [31:0] dbase;
    logic [13:0] hdr_a;
    logic [31:0] hdr_d;
    logic [1:0]  full;
    logic [15:0] seq;
    logic        trunc;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: payload words at base+1.., truncated to 8191, then header
  task automatic model_frame();
    int          n;
    int          plen;
    logic [13:0] base;
    wr_t         w;
    n    = fq.size();
    plen = (n > 8191) ? 8191 : n;
    base = (m_cur != 0) ? 14'h2000 : 14'h0000;
    for (int i = 0; i < plen; i++) begin
      w.a = base + 14'(i + 1);
      w.d = fq[i];
      exp_q.push_back(w);
    end
    w.a = base;
    w.d = {16'(m_seq), 16'(plen)};
    exp_q.push_back(w);
    m_seq = (m_seq + 1) % 65536;
    m_cur = 1 - m_cur;
  endtask

  task automatic fill_frame(input int n, input logic [31:0] base, input bit rnd);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(rnd ? 32'($urandom) : base + 32'(i));
  endtask

  task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop, input int gap);
    bit acc;
    acc = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    st_valid = 1'b1; st_data = d; st_sop = sop; st_eop = eop;
    for (int k = 0; k < 5000; k++) begin
      #1;
      if (st_ready === 1'b1) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) begin
      @(posedge clk);
      #1;
    end else begin
      checks++; errors++;
      $display("FAIL beat_accept: st_ready never rose, required 1 within 5000 cycles");
    end
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
  endtask

  task automatic send_beats(input bit rgap);
    int g;
    for (int i = 0; i < fq.size(); i++) begin
      g = (rgap && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_beat(fq[i], i == 0, i == fq.size() - 1, g);
    end
  endtask

  task automatic release_buf(input logic [1:0] m);
    @(negedge clk); buf_release = m;
    @(negedge clk); buf_release = 2'b00;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    @(negedge clk); @(negedge clk); #1;
  endtask

  // Write monitor: a handshake seen here completes at the next rising edge
  initial begin
    wr_t e;
    forever begin
      @(negedge clk); #2;
      if (mon_en && reset_n && avm_write && !avm_waitrequest) begin
        wr_count++;
        last_a = avm_address;
        last_d = avm_writedata;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write",
                   avm_address, avm_writedata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(avm_address), 64'(e.a));
          chk("wr_data", 64'(avm_writedata), 64'(e.d));
        end
      end
    end
  end

  // Random interconnect stalls
  initial forever begin
    @(negedge clk);
    if (rnd_stall) avm_waitrequest = ($urandom_range(0, 3) == 0);
  end

  // Random host that frees full halves
  initial begin
    logic [1:0] m;
    forever begin
      @(negedge clk);
      if (auto_rel) begin
        m = buf_full & {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
        buf_release = m;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [13:0] base;
    int          w0;

    tbl[0] = '{2'b00, 4,    32'h000000A0, 14'h0000, 32'h00000004, 2'b01, 16'd1, 1'b0};
    tbl[1] = '{2'b00, 2,    32'h000000B0, 14'h2000, 32'h00010002, 2'b11, 16'd2, 1'b0};
    tbl[2] = '{2'b01, 8200, 32'h10000000, 14'h0000, 32'h00021FFF, 2'b11, 16'd3, 1'b1};
    tbl[3] = '{2'b10, 1,    32'h000000C7, 14'h2000, 32'h00030001, 2'b11, 16'd4, 1'b1};

    reset_n = 1'b0; st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    avm_waitrequest = 1'b0; enable = 1'b1; buf_release = 2'b00; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_st_ready", 64'(st_ready), 0);
    chk("rst_avm_write", 64'(avm_write), 0);
    chk("rst_avm_address", 64'(avm_address), 0);
    chk("rst_avm_writedata", 64'(avm_writedata), 0);
    chk("rst_buf_full", 64'(buf_full), 0);
    chk("rst_irq", 64'(irq), 0);
    chk("rst_trunc_err", 64'(trunc_err), 0);
    chk("rst_frame_seq", 64'(frame_seq), 0);
    @(negedge clk); reset_n = 1'b1;

    // Directed frame table
    for (int v = 0; v < 4; v++) begin
      if (tbl[v].rel != 2'b00) release_buf(tbl[v].rel);
      fill_frame(tbl[v].n, tbl[v].dbase, 1'b0);
      model_frame();
      send_beats(1'b0);
      wait_drain();
      chk("tbl_hdr_addr", 64'(last_a), 64'(tbl[v].hdr_a));
      chk("tbl_hdr_data", 64'(last_d), 64'(tbl[v].hdr_d));
      chk("tbl_buf_full", 64'(buf_full), 64'(tbl[v].full));
      chk("tbl_irq", 64'(irq), 64'(|tbl[v].full));
      chk("tbl_frame_seq", 64'(frame_seq), 64'(tbl[v].seq));
      chk("tbl_trunc_err", 64'(trunc_err), 64'(tbl[v].trunc));
    end

    // Clear sticky truncation flag
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0; #1;
    chk("clr_err", 64'(trunc_err), 0);

    // Both halves full: sop held off until the host frees half 0
    fill_frame(3, 32'h000000D0, 1'b0);
    model_frame();
    @(negedge clk);
    st_valid = 1'b1; st_data = fq[0]; st_sop = 1'b1; st_eop = 1'b0;
    w0 = wr_count;
    for (int k = 0; k < 5; k++) begin
      #1; chk("holdoff_ready", 64'(st_ready), 0);
      @(negedge clk);
    end
    buf_release = 2'b01;
    #1; chk("holdoff_release_cycle", 64'(st_ready), 0);
    @(negedge clk); buf_release = 2'b00; st_valid = 1'b0; st_sop = 1'b0;
    chk("holdoff_no_write", 64'(wr_count), 64'(w0));
    send_beats(1'b0);
    wait_drain();
    chk("holdoff_hdr_data", 64'(last_d), 64'h00040003);
    chk("holdoff_buf_full", 64'(buf_full), 64'h3);

    // Interconnect stall mid-frame
    release_buf(2'b11);
    fill_frame(6, 32'h000000E0, 1'b0);
    base = (m_cur != 0) ? 14'h2000 : 14'h0000;
    model_frame();
    send_beat(fq[0], 1'b1, 1'b0, 0);
    send_beat(fq[1], 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      avm_waitrequest = 1'b1;
      st_valid = 1'b1; st_data = fq[2]; st_sop = 1'b0; st_eop = 1'b0;
      #1;
      chk("stall_ready", 64'(st_ready), 0);
      chk("stall_write", 64'(avm_write), 1);
      chk("stall_addr", 64'(avm_address), 64'(base + 14'd2));
      chk("stall_data", 64'(avm_writedata), 64'(fq[1]));
    end
    @(negedge clk); avm_waitrequest = 1'b0; st_valid = 1'b0;
    for (int i = 2; i < 6; i++) send_beat(fq[i], 1'b0, i == 5, 0);
    wait_drain();
    chk("stall_hdr_data", 64'(last_d), 64'h00050006);
    chk("stall_buf_full", 64'(buf_full), 64'h2);

    // Beats without sop in IDLE are dropped
    w0 = wr_count;
    for (int k = 0; k < 3; k++) send_beat(32'hDEAD0000 + 32'(k), 1'b0, k == 2, 0);
    repeat (4) @(negedge clk);
    chk("nosop_no_write", 64'(wr_count), 64'(w0));

    // Single-beat frame and latency of payload, header and flag
    fill_frame(1, 32'h000000F1, 1'b0);
    model_frame();
    send_beat(fq[0], 1'b1, 1'b1, 0);
    @(negedge clk); #1;
    chk("lat1_write", 64'(avm_write), 1);
    chk("lat1_addr", 64'(avm_address), 64'h0001);
    chk("lat1_data", 64'(avm_writedata), 64'h000000F1);
    chk("lat1_byteenable", 64'(avm_byteenable), 64'hF);
    chk("lat1_hdr_ready", 64'(st_ready), 0);
    @(negedge clk); #1;
    chk("lat2_write", 64'(avm_write), 1);
    chk("lat2_addr", 64'(avm_address), 64'h0000);
    chk("lat2_data", 64'(avm_writedata), 64'h00060001);
    chk("lat2_buf_full", 64'(buf_full), 64'h2);
    @(negedge clk); #1;
    chk("lat3_buf_full", 64'(buf_full), 64'h3);
    chk("lat3_irq", 64'(irq), 1);
    chk("lat3_frame_seq", 64'(frame_seq), 64'd7);

    // enable falls mid-frame: frame finishes, next one is held off
    release_buf(2'b11);
    fill_frame(3, 32'h00000A50, 1'b0);
    model_frame();
    send_beat(fq[0], 1'b1, 1'b0, 0);
    enable = 1'b0;
    send_beat(fq[1], 1'b0, 1'b0, 0);
    send_beat(fq[2], 1'b0, 1'b1, 0);
    wait_drain();
    chk("en_buf_full", 64'(buf_full), 64'h2);
    w0 = wr_count;
    @(negedge clk);
    st_valid = 1'b1; st_data = 32'h0BAD0BAD; st_sop = 1'b1; st_eop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1; chk("en_hold_ready", 64'(st_ready), 0);
      @(negedge clk);
    end
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; enable = 1'b1;
    chk("en_no_write", 64'(wr_count), 64'(w0));

    // Reset during FILL abandons the frame
    mon_en = 1'b0;
    send_beat(32'h00000C01, 1'b1, 1'b0, 0);
    send_beat(32'h00000C02, 1'b0, 1'b0, 0);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); #1;
    chk("midrst_st_ready", 64'(st_ready), 0);
    chk("midrst_avm_write", 64'(avm_write), 0);
    chk("midrst_avm_address", 64'(avm_address), 0);
    chk("midrst_avm_writedata", 64'(avm_writedata), 0);
    chk("midrst_buf_full", 64'(buf_full), 0);
    chk("midrst_irq", 64'(irq), 0);
    chk("midrst_frame_seq", 64'(frame_seq), 0);
    reset_n = 1'b1;
    exp_q.delete(); m_cur = 0; m_seq = 0;
    mon_en = 1'b1;
    fill_frame(2, 32'h00000C10, 1'b0);
    model_frame();
    send_beats(1'b0);
    wait_drain();
    chk("postrst_hdr_addr", 64'(last_a), 64'h0000);
    chk("postrst_hdr_data", 64'(last_d), 64'h00000002);
    chk("postrst_frame_seq", 64'(frame_seq), 64'd1);

    // Randomized frames with stalls, gaps, stray beats and a random host
    auto_rel = 1'b1;
    rnd_stall = 1'b1;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0)
        send_beat(32'($urandom), 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      fill_frame(int'($urandom_range(1, 12)), 32'h0, 1'b1);
      model_frame();
      send_beats(1'b1);
    end
    rnd_stall = 1'b0;
    avm_waitrequest = 1'b0;
    wait_drain();
    chk("rnd_trunc_err", 64'(trunc_err), 0);
    chk("rnd_frame_seq", 64'(frame_seq), 64'(m_seq));
    auto_rel = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_daq_frame_ram_writer
